// File: rtl/wb_reg_responder_if.sv
// Wishbone classic bus bundle for the 8-bit, 3-bit-address host register bus.
interface wb_reg_responder_if;
  logic [2:0] WB_ADDR;
  logic [3:0] WB_SEL;
  logic [7:0] WB_DAT_I;
  logic [7:0] WB_DAT_O;
  logic       WB_WE;
  logic       WB_STB;
  logic       WB_CYC;
  logic       WB_ACK;

  modport master (
    output WB_ADDR, WB_SEL, WB_DAT_I, WB_WE, WB_STB, WB_CYC,
    input  WB_DAT_O, WB_ACK
  );

  modport slave (
    input  WB_ADDR, WB_SEL, WB_DAT_I, WB_WE, WB_STB, WB_CYC,
    output WB_DAT_O, WB_ACK
  );
endinterface

// File: rtl/wb_reg_responder.sv
// Wishbone classic responder: CTRL/STATUS/SCRATCH registers plus a TX byte
// FIFO that drains over a valid/ready stream toward a serializer.
module wb_reg_responder #(
  parameter int WAIT_STATES = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              WBCLK,
  input  logic              WBRST,
  wb_reg_responder_if.slave bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0]    WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_d;
  logic [1:0]  wcnt;
  logic        req;

  // Transfer captured at the request edge, used for wait-state commits and read muxing.
  logic [2:0]  addr_q;
  logic        we_q;
  logic [7:0]  dat_q;
  logic        sel_q;

  // Write being committed this cycle (from the bus directly or from the capture).
  logic        commit;
  logic [2:0]  c_addr;
  logic        c_we;
  logic [7:0]  c_dat;
  logic        c_sel;

  logic        wr_en, push, ctrl_wr, stat_wr, scr_wr, flush;
  logic        pop, push_ok, ovf_set;

  logic [7:0]  ctrl, scratch;
  logic        overflow;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    count4;
  logic          empty, full;
  logic [7:0]    status, rd_mux;

  logic unused_sel;
  assign unused_sel = ^bus.WB_SEL[3:1];

  assign req = bus.WB_CYC & bus.WB_STB;

  // FSM state and wait-state counter.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge WBCLK or negedge WBRST) begin
    if (!WBRST) begin
      state <= S_IDLE;
      wcnt  <= 2'd0;
    end else begin
      state <= state_d;
      wcnt  <= (state == S_WAIT && state_d == S_WAIT) ? wcnt + 2'd1 : 2'd0;
    end
  end

  // Capture the request when it is first seen in IDLE.
  always_ff @(posedge WBCLK or negedge WBRST) begin
    if (!WBRST) begin
      addr_q <= 3'd0;
      we_q   <= 1'b0;
      dat_q  <= 8'h00;
      sel_q  <= 1'b0;
    end else if (state == S_IDLE && req) begin
      addr_q <= bus.WB_ADDR;
      we_q   <= bus.WB_WE;
      dat_q  <= bus.WB_DAT_I;
      sel_q  <= bus.WB_SEL[0];
    end
  end

  // Next-state logic; the write commits on the edge that enters ACK.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    commit  = 1'b0;
    c_addr  = addr_q;
    c_we    = we_q;
    c_dat   = dat_q;
    c_sel   = sel_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
            c_addr  = bus.WB_ADDR;
            c_we    = bus.WB_WE;
            c_dat   = bus.WB_DAT_I;
            c_sel   = bus.WB_SEL[0];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (wcnt == WS_LAST) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register-map decode of the committed write.
  assign wr_en   = commit & c_we & c_sel;
  assign push    = wr_en && (c_addr == 3'd0);
  assign ctrl_wr = wr_en && (c_addr == 3'd1);
  assign stat_wr = wr_en && (c_addr == 3'd2);
  assign scr_wr  = wr_en && (c_addr == 3'd3);
  assign flush   = ctrl_wr & c_dat[1];

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop     = tx_valid & tx_ready;
  assign push_ok = push & ~flush & (~full | pop);
  assign ovf_set = push & ~flush & full & ~pop;

  // CTRL, SCRATCH and the sticky overflow flag; the flush bit is never stored.
  always_ff @(posedge WBCLK or negedge WBRST) begin
    if (!WBRST) begin
      ctrl     <= 8'h00;
      scratch  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl    <= c_dat & 8'hFD;
      if (scr_wr)  scratch <= c_dat;
      if (stat_wr && c_dat[2]) overflow <= 1'b0;
      else if (ovf_set)        overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge WBCLK or negedge WBRST) begin
    if (!WBRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  // NOTE: the data array has no reset; empty gates tx_data so stale contents never escape.
  always_ff @(posedge WBCLK) begin
    if (push_ok) mem[wr_ptr] <= c_dat;
  end

  // Interrupt is registered from current CTRL and FIFO status.
  always_ff @(posedge WBCLK or negedge WBRST) begin
    if (!WBRST) irq <= 1'b0;
    else        irq <= (ctrl[0] & empty) | (ctrl[2] & overflow);
  end

  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : mem[rd_ptr];

  assign count4 = 4'(count);
  assign status = {count4, 1'b0, overflow, full, empty};

  // Read data multiplexer, keyed by the captured address.
  always_comb begin
    rd_mux = 8'h00;
    case (addr_q)
      3'd1:    rd_mux = ctrl;
      3'd2:    rd_mux = status;
      3'd3:    rd_mux = scratch;
      default: rd_mux = 8'h00;
    endcase
  end

  assign bus.WB_ACK   = (state == S_ACK);
  assign bus.WB_DAT_O = (state == S_ACK && !we_q) ? rd_mux : 8'h00;

endmodule

// File: doc/wb_reg_responder.md
Name: wb_reg_responder

Overview:
- Wishbone classic slave (responder) on the 8-bit, 3-bit-address UART host bus.
- Decodes a small register map: control, status, scratch, and a TX byte FIFO.
- Drains the TX FIFO on a valid/ready byte stream toward a downstream serializer.
- Used as the DUT-side counterpart for exercising the Wishbone master agent, and as a building block for host-facing register logic.

Parameters:
- WAIT_STATES, 0: extra cycles inserted before ACK. Legal range 0..3.
- FIFO_DEPTH, 4: TX FIFO entries. Power of 2, range 2..8.

Ports:
- WBCLK  in  1  bus clock; all logic is rising-edge.
- WBRST  in  1  asynchronous, active-low reset.
- WB_ADDR  in  3  register address.
- WB_SEL  in  4  byte select; only bit 0 qualifies writes.
- WB_DAT_I  in  8  write data from master.
- WB_DAT_O  out  8  read data to master.
- WB_WE  in  1  1 = write, 0 = read.
- WB_STB  in  1  strobe.
- WB_CYC  in  1  cycle valid.
- WB_ACK  out  1  transfer acknowledge.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts the head byte.
- irq  out  1  registered interrupt.

Behaviour:
- Reset (WBRST=0, asynchronous):
  - Outputs: WB_ACK=0, WB_DAT_O=0x00, tx_valid=0, tx_data=0x00, irq=0.
  - State: FIFO empty, CTRL=0x00, SCRATCH=0x00, overflow=0, FSM=IDLE.
  - Reset asserted mid-transfer discards the transfer and drops ACK immediately.
- Request: req = WB_CYC & WB_STB.
- FSM:
  - IDLE: on req, latch ADDR/WE/DAT_I/SEL[0]. Go to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: count WAIT_STATES cycles, then go to ACK. If req drops, abort to IDLE with no side effects and no ACK.
  - ACK: WB_ACK=1 for exactly one cycle, then IDLE. IDLE does not sample req in the cycle ACK is high, so at least one idle cycle separates transfers.
- Timing:
  - req first sampled at edge k → WB_ACK high in the cycle after edge k+WAIT_STATES. With WAIT_STATES=0, ACK is high in the cycle following the request edge.
  - Write side effects occur at the edge where ACK rises.
  - WB_DAT_O carries read data only while ACK=1, and is 0x00 otherwise.
- Register map:
  - 0, TXD. Write pushes a byte to the FIFO. Read returns 0x00.
  - 1, CTRL (R/W). bit0 = irq on empty, bit1 = flush (self-clearing, reads 0), bit2 = irq on overflow. Other bits are stored and read back.
  - 2, STATUS (RO, except W1C). bit0 = empty, bit1 = full, bit2 = overflow (sticky; writing 1 to bit2 clears it), bit3 = 0, bits[7:4] = count.
  - 3, SCRATCH (R/W).
  - 4..7: reads return 0x00, writes are ignored, ACK is still given.
  - A write with WB_SEL[0]=0 is ACKed but has no effect.
- FIFO:
  - tx_valid = !empty; tx_data = head byte (0x00 when empty).
  - Pop occurs on tx_valid & tx_ready.
  - Push while full with no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only, since tx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flush resets count and pointers. Flush in the same cycle as a push: flush wins, byte dropped, no overflow set.
- irq: registered (CTRL[0] & empty) | (CTRL[2] & overflow), updated every cycle.

Test Plan:
- Reset, then read addr 2 (WAIT_STATES=0) → ACK one cycle after req, WB_DAT_O=0x01; tx_valid=0, irq=0.
- Write 0xA5 to addr 3, read back with WAIT_STATES=2 → ACK in the 3rd cycle after req, data 0xA5. Read addr 5 → 0x00.
- Hold tx_ready=0; write 0x11, 0x22, 0x33, 0x44, 0x55 to addr 0 → STATUS=0x46 (count 4, full, overflow). Raise tx_ready → tx_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then tx_valid=0.
- Full FIFO, write addr 0 in the same cycle that tx_ready pops → no overflow, count stays 4. Write 0x04 to addr 2 → overflow cleared.
- WAIT_STATES=3: drop STB after 1 wait cycle on a write to addr 3 → no ACK, SCRATCH unchanged. Write with WB_SEL=0x0 → ACK, no change.
- Set CTRL=0x01 with FIFO empty → irq=1. Push one byte → irq=0. Assert WBRST mid-wait → WB_ACK=0 immediately, all state at reset values.
